// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   localparam int unsigned SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_fa.sv
// Single-bit full adder cell, sequenced over the operand bits by serial_add_ctrl.
module serial_add_fa (
   input  logic a,
   input  logic b,
   input  logic carry,
   output logic sum,
   output logic carryout
);

   assign sum      = a ^ b ^ carry;
   assign carryout = (a & b) | (carry & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder cell reused over WIDTH cycles, LSB first,
// with a start/done handshake and registered sum/cout/ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CntW = $clog2(WIDTH);

   sa_state_t        state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CntW-1:0]  cnt;

   logic             fa_sum;
   logic             fa_co;
   logic [WIDTH-1:0] res_next;
   logic             last_bit;

   serial_add_fa u_fa (
      .a        (a_sh[0]),
      .b        (b_sh[0]),
      .carry    (carry),
      .sum      (fa_sum),
      .carryout (fa_co)
   );

   // New result bit enters at the MSB; after WIDTH shifts the word is aligned.
   assign res_next = WIDTH'({fa_sum, res_sh} >> 1);
   assign last_bit = (cnt == CntW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               carry  <= fa_co;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  // carry still holds the carry into the MSB at this edge
                  sum   <= res_next;
                  cout  <= fa_co;
                  ovf   <= carry ^ fa_co;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready = (state == IDLE) || (state == DONE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, cout, sum[7:0]} from plain integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci, input logic s);
      logic signed [7:0] xs;
      logic signed [7:0] ys;
      int                sx;
      int                sy;
      int                ux;
      int                uy;
      int                ures;
      int                sres;
      logic              c;
      logic              v;
      logic [7:0]        r;
      xs = x;
      ys = y;
      sx = xs;
      sy = ys;
      ux = int'(x);
      uy = int'(y);
      if (s) begin
         ures = ux - uy;
         c    = (ux >= uy);
         sres = sx - sy;
      end else begin
         ures = ux + uy + int'(ci);
         c    = (ures > 255);
         sres = sx + sy + int'(ci);
      end
      r = ures[7:0];
      v = (sres > 127) || (sres < -128);
      return {v, c, r};
   endfunction

   task automatic drive_start(input logic [7:0] x, input logic [7:0] y,
                              input logic ci, input logic s);
      @(negedge clk);
      a     = x;
      b     = y;
      cin   = ci;
      sub   = s;
      start = 1'b1;
   endtask

   task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic s, input bit poke);
      logic [9:0] exp;
      int         first;
      int         ndone;
      int         nbusy;
      logic [9:0] got;
      exp   = model(x, y, ci, s);
      first = 0;
      ndone = 0;
      nbusy = 0;
      got   = '0;
      check({tag, "_ready"}, 32'(ready), 32'd1);
      drive_start(x, y, ci, s);
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
         end
         if (poke && i == 3) start = 1'b1;
         if (poke && i == 4) start = 1'b0;
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (first == 0) begin
               first = i;
               got   = {ovf, cout, sum};
            end
         end
      end
      check({tag, "_latency"}, 32'(first), 32'd9);
      check({tag, "_ndone"}, 32'(ndone), 32'd1);
      check({tag, "_busy"}, 32'(nbusy), 32'd8);
      check({tag, "_sum"}, 32'(got[7:0]), 32'(exp[7:0]));
      check({tag, "_cout"}, 32'(got[8]), 32'(exp[8]));
      check({tag, "_ovf"}, 32'(got[9]), 32'(exp[9]));
      check({tag, "_hold"}, 32'(sum), 32'(exp[7:0]));
   endtask

   initial begin
      logic [9:0] e1;
      logic [9:0] e2;
      int         d1;
      int         d2;
      int         nd;

      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", 32'({ovf, cout, sum}), 32'd0);
      rst = 1'b0;

      do_op("add_basic", 8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
      do_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      do_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      do_op("add_cin", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
      do_op("sub_neg", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      do_op("sub_pos", 8'h20, 8'h10, 1'b1, 1'b1, 1'b0);
      do_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
      do_op("mid_start", 8'h5A, 8'h21, 1'b0, 1'b0, 1'b1);

      // Reset mid-operation: result from the previous op (0x7B) must be cleared.
      drive_start(8'hAA, 8'h11, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      check("midrst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("midrst_nodone", 32'(nd), 32'd0);
      do_op("after_rst", 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);

      // Back-to-back: start held high, second op accepted in the DONE cycle.
      e1 = model(8'h0F, 8'h01, 1'b0, 1'b0);
      e2 = model(8'h50, 8'h60, 1'b0, 1'b1);
      d1 = 0;
      d2 = 0;
      drive_start(8'h0F, 8'h01, 1'b0, 1'b0);
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         if (i == 1) begin
            a   = 8'h50;
            b   = 8'h60;
            sub = 1'b1;
         end
         if (i == 10) start = 1'b0;
         if (done) begin
            if (d1 == 0) d1 = i;
            else if (d2 == 0) d2 = i;
         end
         if (i == 9) check("b2b_sum1", 32'(sum), 32'(e1[7:0]));
         if (i == 13) check("b2b_hold", 32'(sum), 32'(e1[7:0]));
         if (i == 18) check("b2b_sum2", 32'({ovf, cout, sum}), 32'(e2));
      end
      check("b2b_done1", 32'(d1), 32'd9);
      check("b2b_done2", 32'(d2), 32'd18);

      for (int n = 0; n < 24; n++) begin
         do_op($sformatf("rnd%0d", n), 8'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom), bit'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
